conv_mem_responder: RTL and testbench

Memory-side responder for the CONV accelerator. It holds the 64x64 input image plus the layer-0 (4096-word) and layer-1 (1024-word) result memories. It drives the `ready`/`idata`/`cdata_rd` side of the CONV interface and tracks the run from start pulse to `busy` falling. A host loads the image, starts the run, reads back results, and checks the write counters and checksum.

---
 rtl/conv_mem_responder.sv | 195 +++++++++++++++++++
 tb/tb_conv_mem_responder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mem_responder.sv
// Memory-side responder for the CONV accelerator: image, layer-0 and layer-1 memories plus run tracking.
// Define CONV_RESP_CHECK_EN to flag illegal accesses on err in addition to the run timeout.
module conv_mem_responder #(
    parameter int TIMEOUT = 1048575,
    parameter int CHK_W   = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                ld_valid,
    input  logic [11:0]         ld_addr,
    input  logic [19:0]         ld_data,
    output logic                ready,
    input  logic                busy,
    input  logic [11:0]         iaddr,
    output logic signed [19:0]  idata,
    input  logic                cwr,
    input  logic [11:0]         caddr_wr,
    input  logic [19:0]         cdata_wr,
    input  logic                crd,
    input  logic [11:0]         caddr_rd,
    output logic [19:0]         cdata_rd,
    input  logic [2:0]          csel,
    input  logic                rb_sel,
    input  logic [11:0]         rb_addr,
    output logic [19:0]         rb_data,
    output logic                done,
    output logic                err,
    output logic [12:0]         wr_cnt_l0,
    output logic [10:0]         wr_cnt_l1,
    output logic [CHK_W-1:0]    chk
);

    localparam int RUN_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);
    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t           state;
    logic             seen_busy;
    logic [RUN_W-1:0] run_cnt;

    logic [19:0] img_mem [4096];
    logic [19:0] l0_mem  [4096];
    logic [19:0] l1_mem  [1024];

    logic wr_l0;
    logic wr_l1;
    logic load_ok;
    logic start_ok;
    logic run_end;
    logic timeout_hit;
    logic viol;

    function automatic logic [12:0] sat_inc_l0(input logic [12:0] c);
        return (c == 13'd4096) ? c : c + 13'd1;
    endfunction

    function automatic logic [10:0] sat_inc_l1(input logic [10:0] c);
        return (c == 11'd1024) ? c : c + 11'd1;
    endfunction

    function automatic logic [CHK_W-1:0] chk_add(input logic [CHK_W-1:0] acc,
                                                 input logic [19:0]      d);
        return acc + CHK_W'(d);
    endfunction

    always_comb begin
        wr_l0       = cwr && (csel == CSEL_L0);
        wr_l1       = cwr && (csel == CSEL_L1);
        load_ok     = ld_valid && (state == IDLE || state == DONE);
        start_ok    = start && (state == IDLE || state == DONE);
        // A busy-fall ends the run normally even on the last permitted cycle.
        run_end     = (state == RUN) && !busy && seen_busy;
        timeout_hit = (state == RUN) && !run_end && (run_cnt == RUN_LAST);
    end

`ifdef CONV_RESP_CHECK_EN
    logic map_ok;
    logic l1_hi;

    always_comb begin
        map_ok = (csel == CSEL_L0) || (csel == CSEL_L1);
        l1_hi  = (csel == CSEL_L1) &&
                 ((cwr && (caddr_wr[11:10] != 2'b00)) || (crd && (caddr_rd[11:10] != 2'b00)));
        viol   = (cwr && crd)
               || ((cwr || crd) && !map_ok)
               || l1_hi
               || (ld_valid && (state == ARM || state == RUN))
               || (cwr && (state != RUN));
    end
`else
    assign viol = 1'b0;
`endif

    // Memory arrays: no reset of contents, but a write landing while reset is held is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (reset) begin
            if (load_ok) begin
                img_mem[ld_addr] <= ld_data;
            end
            if (wr_l0) begin
                l0_mem[caddr_wr] <= cdata_wr;
            end
            if (wr_l1) begin
                l1_mem[caddr_wr[9:0]] <= cdata_wr;
            end
        end
    end

    assign idata   = img_mem[iaddr];
    assign rb_data = rb_sel ? l1_mem[rb_addr[9:0]] : l0_mem[rb_addr];

    always_comb begin
        cdata_rd = '0;
        if (crd && (csel == CSEL_L0)) begin
            cdata_rd = l0_mem[caddr_rd];
        end else if (crd && (csel == CSEL_L1)) begin
            cdata_rd = l1_mem[caddr_rd[9:0]];
        end
    end

    // Write accounting: a starting run clears the statistics, overriding any same-edge write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt_l0 <= '0;
            wr_cnt_l1 <= '0;
            chk       <= '0;
            err       <= 1'b0;
        end else if (start_ok) begin
            wr_cnt_l0 <= '0;
            wr_cnt_l1 <= '0;
            chk       <= '0;
            err       <= 1'b0;
        end else begin
            if (wr_l0) begin
                wr_cnt_l0 <= sat_inc_l0(wr_cnt_l0);
            end
            if (wr_l1) begin
                wr_cnt_l1 <= sat_inc_l1(wr_cnt_l1);
            end
            if (wr_l0 || wr_l1) begin
                chk <= chk_add(chk, cdata_wr);
            end
            if (timeout_hit || viol) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ready     <= 1'b0;
            done      <= 1'b0;
            seen_busy <= 1'b0;
            run_cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= ARM;
                        ready     <= 1'b1;
                        done      <= 1'b0;
                        seen_busy <= 1'b0;
                        run_cnt   <= '0;
                    end
                end
                ARM: begin
                    state <= RUN;
                    ready <= 1'b0;
                end
                RUN: begin
                    if (busy) begin
                        seen_busy <= 1'b1;
                    end
                    if (run_end || timeout_hit) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + RUN_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mem_responder.sv
// Directed/randomized bench for conv_mem_responder against a behavioural memory and run model.
module tb_conv_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [19:0] ld_data = '0;
    logic        busy = 1'b0;
    logic [11:0] iaddr = '0;
    logic        cwr = 1'b0;
    logic [11:0] caddr_wr = '0;
    logic [19:0] cdata_wr = '0;
    logic        crd = 1'b0;
    logic [11:0] caddr_rd = '0;
    logic [2:0]  csel = '0;
    logic        rb_sel = 1'b0;
    logic [11:0] rb_addr = '0;

    logic               ready, done, err;
    logic signed [19:0] idata;
    logic [19:0]        cdata_rd, rb_data;
    logic [12:0]        wr_cnt_l0;
    logic [10:0]        wr_cnt_l1;
    logic [23:0]        chk;

    logic               ready_t, done_t, err_t;
    logic signed [19:0] idata_t;
    logic [19:0]        cdata_rd_t, rb_data_t;
    logic [12:0]        wr_cnt_l0_t;
    logic [10:0]        wr_cnt_l1_t;
    logic [23:0]        chk_t;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    conv_mem_responder dut (
        .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
        .cdata_rd(cdata_rd), .csel(csel), .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(rb_data),
        .done(done), .err(err), .wr_cnt_l0(wr_cnt_l0), .wr_cnt_l1(wr_cnt_l1), .chk(chk)
    );

    conv_mem_responder #(.TIMEOUT(16)) dut_t (
        .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .ready(ready_t), .busy(busy), .iaddr(iaddr), .idata(idata_t),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
        .cdata_rd(cdata_rd_t), .csel(csel), .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(rb_data_t),
        .done(done_t), .err(err_t), .wr_cnt_l0(wr_cnt_l0_t), .wr_cnt_l1(wr_cnt_l1_t), .chk(chk_t)
    );

    // Reference model of the main instance
    typedef enum {P_IDLE, P_ARM, P_RUN, P_DONE} phase_t;
    phase_t      ph = P_IDLE;
    bit          seen_m = 1'b0;
    bit          err_m = 1'b0;
    int          cnt0_m = 0;
    int          cnt1_m = 0;
    logic [23:0] chk_m = '0;
    logic [19:0] img_m [4096];
    logic [19:0] l0_m  [4096];
    logic [19:0] l1_m  [1024];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit tb_viol();
`ifdef CONV_RESP_CHECK_EN
        bit mapped;
        mapped = (csel == 3'd1) || (csel == 3'd3);
        return (cwr && crd) || ((cwr || crd) && !mapped)
            || ((csel == 3'd3) && ((cwr && caddr_wr > 12'd1023) || (crd && caddr_rd > 12'd1023)))
            || (ld_valid && (ph == P_ARM || ph == P_RUN))
            || (cwr && ph != P_RUN);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [19:0] exp_cdata();
        if (crd && csel == 3'd1) return l0_m[caddr_rd];
        if (crd && csel == 3'd3) return l1_m[caddr_rd % 1024];
        return 20'd0;
    endfunction

    function automatic logic [19:0] exp_rb();
        return rb_sel ? l1_m[rb_addr % 1024] : l0_m[rb_addr];
    endfunction

    task automatic model_reset();
        ph = P_IDLE; seen_m = 0; err_m = 0; cnt0_m = 0; cnt1_m = 0; chk_m = '0;
    endtask

    // Advance one clock edge, applying the spec's rules to the model first.
    task automatic step();
        bit v;
        v = tb_viol();
        if (cwr && csel == 3'd1) begin
            l0_m[caddr_wr] = cdata_wr;
            if (cnt0_m < 4096) cnt0_m++;
            chk_m = chk_m + {4'd0, cdata_wr};
        end else if (cwr && csel == 3'd3) begin
            l1_m[caddr_wr % 1024] = cdata_wr;
            if (cnt1_m < 1024) cnt1_m++;
            chk_m = chk_m + {4'd0, cdata_wr};
        end
        if (ld_valid && (ph == P_IDLE || ph == P_DONE)) img_m[ld_addr] = ld_data;
        if (v) err_m = 1;
        case (ph)
            P_IDLE, P_DONE: if (start) begin
                ph = P_ARM; cnt0_m = 0; cnt1_m = 0; chk_m = '0; err_m = 0; seen_m = 0;
            end
            P_ARM: ph = P_RUN;
            default: begin
                if (!busy && seen_m) ph = P_DONE;
                if (busy) seen_m = 1;
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag);
        check({tag, "_ready"}, ready, ph == P_ARM);
        check({tag, "_done"}, done, ph == P_DONE);
        check({tag, "_err"}, err, err_m);
        check({tag, "_cnt0"}, wr_cnt_l0, cnt0_m);
        check({tag, "_cnt1"}, wr_cnt_l1, cnt1_m);
        check({tag, "_chk"}, chk, chk_m);
    endtask

    task automatic idle_bus();
        cwr = 0; crd = 0; ld_valid = 0; start = 0; csel = 3'd0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #3;
        check_ctrl("reset");
        @(posedge clk); #1;
        reset = 1;

        for (int k = 0; k < 4095; k++) begin
            ld_valid = 1; ld_addr = 12'(k); ld_data = 20'(k);
            step();
        end
        ld_valid = 0;

        cwr = 1; csel = 3'b001;
        for (int k = 0; k < 4100; k++) begin
            caddr_wr = 12'(k % 4096); cdata_wr = 20'($urandom);
            step();
        end
        csel = 3'b011;
        for (int k = 0; k < 1030; k++) begin
            caddr_wr = 12'(k % 1024); cdata_wr = 20'($urandom);
            step();
        end
        idle_bus();
        check_ctrl("prefill");
        check("sat_l0", wr_cnt_l0, 13'd4096);
        check("sat_l1", wr_cnt_l1, 11'd1024);
        for (int k = 0; k < 4; k++) begin
            rb_sel = k[0]; rb_addr = 12'($urandom);
            #1;
            check("prefill_rb", rb_data, exp_rb());
        end

        ld_valid = 1; ld_addr = 12'd4095; ld_data = 20'd4095; start = 1;
        step();
        idle_bus();
        check_ctrl("arm");
        iaddr = 12'd5; #1;
        check("idata5", $unsigned(idata), 20'd5);
        iaddr = 12'd4095; #1;
        check("idata_ld_start", $unsigned(idata), 20'd4095);
        step();
        check_ctrl("run");

        ld_valid = 1; ld_addr = 12'd7; ld_data = 20'hFFFFF;
        step();
        ld_valid = 0; iaddr = 12'd7; #1;
        check("ld_in_run", $unsigned(idata), 20'd7);
        check_ctrl("ld_run");

        cwr = 1; csel = 3'b001; caddr_wr = 12'd100; cdata_wr = 20'h00ABC;
        crd = 1; caddr_rd = 12'd100; #1;
        check("rdw_old", cdata_rd, exp_cdata());
        step();
        cwr = 0; #1;
        check("rdw_new", cdata_rd, 20'h00ABC);
        check("l0_cnt1", wr_cnt_l0, 13'd1);
        check("l0_chk", chk, 24'h000ABC);
        check_ctrl("l0wr");

        crd = 0; cwr = 1; csel = 3'b011; caddr_wr = 12'h7FF; cdata_wr = 20'($urandom);
        step();
        cwr = 0; rb_sel = 1; rb_addr = 12'd1023; #1;
        check("l1_alias", rb_data, l1_m[1023]);
        check_ctrl("l1wr");

        cwr = 1; csel = 3'b010; caddr_wr = 12'd5; cdata_wr = 20'h55555;
        crd = 1; caddr_rd = 12'd5; #1;
        check("unmapped_rd", cdata_rd, 20'd0);
        step();
        idle_bus();
        rb_sel = 0; rb_addr = 12'd5; #1;
        check("unmapped_wr", rb_data, l0_m[5]);
        check_ctrl("unmapped");

        for (int i = 0; i < 300; i++) begin
            cwr = ($urandom_range(0, 1) == 1);
            crd = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: csel = 3'b001;
                1: csel = 3'b011;
                2: csel = 3'b010;
                default: csel = 3'($urandom);
            endcase
            caddr_wr = 12'($urandom); caddr_rd = 12'($urandom); cdata_wr = 20'($urandom);
            rb_sel = 1'($urandom); rb_addr = 12'($urandom); iaddr = 12'($urandom);
            ld_valid = ($urandom_range(0, 9) == 0); ld_addr = 12'($urandom); ld_data = 20'($urandom);
            #1;
            check("rand_cdata_rd", cdata_rd, exp_cdata());
            check("rand_rb_data", rb_data, exp_rb());
            check("rand_idata", $unsigned(idata), img_m[iaddr]);
            step();
            if (i % 50 == 49) check_ctrl("rand");
        end
        idle_bus();

        busy = 1;
        for (int i = 0; i < 50; i++) step();
        check_ctrl("busy_hi");
        busy = 0;
        step();
        check_ctrl("busy_fall");

        ld_valid = 1; ld_addr = 12'd9; ld_data = 20'h12345;
        step();
        ld_valid = 0; iaddr = 12'd9; #1;
        check("ld_in_done", $unsigned(idata), 20'h12345);

        start = 1;
        step();
        start = 0;
        check_ctrl("restart");
        step();
        cwr = 1; csel = 3'b001; caddr_wr = 12'd200; cdata_wr = 20'h0BEEF;
        step();
        caddr_wr = 12'd100; cdata_wr = ~l0_m[100];
        reset = 0; #1;
        model_reset();
        check_ctrl("async_rst");
        @(posedge clk); #1;
        idle_bus();
        reset = 1;
        rb_sel = 0; rb_addr = 12'd100; #1;
        check("rst_lost_wr", rb_data, l0_m[100]);
        rb_addr = 12'd200; #1;
        check("rst_keep_mem", rb_data, 20'h0BEEF);
        check_ctrl("post_rst");

        start = 1; busy = 1;
        step();
        start = 0;
        step();
        n = 0;
        while (!done_t && n < 40) begin
            step();
            n++;
        end
        check("timeout_cycles", n, 16);
        check("timeout_err", err_t, 1'b1);
        check_ctrl("no_timeout_main");
        busy = 0;
        step();
        check_ctrl("final_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
